// File: rtl/boot_loader.sv
// Framed byte-stream loader for the single-cycle MIPS DataPath: fills IMEM/DMEM and gates core reset.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte per load frame).
module boot_loader #(
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               core_rst,
    output logic               busy,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_COUNT   = 3'd2,
        S_DATA    = 3'd3,
        S_CSUM    = 3'd4,
        S_RUNNING = 3'd5
    } state_t;

    localparam logic [7:0] CMD_LOAD_I = 8'h01;
    localparam logic [7:0] CMD_LOAD_D = 8'h02;
    localparam logic [7:0] CMD_RUN    = 8'h03;
    localparam logic [7:0] CMD_HALT   = 8'h04;
    localparam logic [7:0] CMD_CLR    = 8'h05;

`ifdef BOOT_CHECKSUM_EN
    function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t             state_r;
    logic               dmem_sel_r;
    logic [IADDR_W-1:0] iptr_r;
    logic [DADDR_W-1:0] dptr_r;
    logic [8:0]         word_cnt_r;
    logic [1:0]         byte_idx_r;
    logic [23:0]        asm_r;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]         csum_r;
`endif
    logic               in_ready_r;
    logic               imem_we_r;
    logic [IADDR_W-1:0] imem_addr_r;
    logic [31:0]        imem_wdata_r;
    logic               dmem_we_r;
    logic [DADDR_W-1:0] dmem_addr_r;
    logic [31:0]        dmem_wdata_r;
    logic               core_rst_r;
    logic               busy_r;
    logic               err_r;
    logic               accept_s;

    assign accept_s   = in_valid & in_ready_r;
    assign in_ready   = in_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign core_rst   = core_rst_r;
    assign busy       = busy_r;
    assign err        = err_r;

    // Frame parser, word assembler, memory write strobes and run/halt control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            dmem_sel_r   <= 1'b0;
            iptr_r       <= '0;
            dptr_r       <= '0;
            word_cnt_r   <= 9'd0;
            byte_idx_r   <= 2'd0;
            asm_r        <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
            in_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= '0;
            dmem_wdata_r <= 32'd0;
            core_rst_r   <= 1'b1;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            in_ready_r <= 1'b1;
            imem_we_r  <= 1'b0;
            dmem_we_r  <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    S_IDLE: begin
                        case (in_data)
                            CMD_LOAD_I, CMD_LOAD_D: begin
                                dmem_sel_r <= (in_data == CMD_LOAD_D);
                                state_r    <= S_ADDR;
                                busy_r     <= 1'b1;
                            end
                            CMD_RUN: begin
                                // A latched error blocks RUN until explicitly cleared.
                                if (!err_r) begin
                                    state_r    <= S_RUNNING;
                                    core_rst_r <= 1'b0;
                                end else begin
                                    state_r <= S_IDLE;
                                end
                            end
                            CMD_HALT: state_r <= S_IDLE;
                            CMD_CLR:  err_r   <= 1'b0;
                            default:  err_r   <= 1'b1;
                        endcase
                    end
                    S_ADDR: begin
                        iptr_r  <= IADDR_W'(in_data);
                        dptr_r  <= DADDR_W'(in_data);
                        state_r <= S_COUNT;
                    end
                    S_COUNT: begin
                        word_cnt_r <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        byte_idx_r <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
                        csum_r     <= 8'd0;
`endif
                        state_r    <= S_DATA;
                    end
                    S_DATA: begin
`ifdef BOOT_CHECKSUM_EN
                        csum_r <= csum_upd(csum_r, in_data);
`endif
                        if (byte_idx_r == 2'd3) begin
                            if (dmem_sel_r) begin
                                dmem_we_r    <= 1'b1;
                                dmem_addr_r  <= dptr_r;
                                dmem_wdata_r <= {asm_r, in_data};
                                dptr_r       <= dptr_r + DADDR_W'(1);
                            end else begin
                                imem_we_r    <= 1'b1;
                                imem_addr_r  <= iptr_r;
                                imem_wdata_r <= {asm_r, in_data};
                                iptr_r       <= iptr_r + IADDR_W'(1);
                            end
                            byte_idx_r <= 2'd0;
                            word_cnt_r <= word_cnt_r - 9'd1;
                            if (word_cnt_r == 9'd1) begin
`ifdef BOOT_CHECKSUM_EN
                                state_r <= S_CSUM;
`else
                                state_r <= S_IDLE;
                                busy_r  <= 1'b0;
`endif
                            end else begin
                                state_r <= S_DATA;
                            end
                        end else begin
                            asm_r      <= {asm_r[15:0], in_data};
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end
                    S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
                        if (csum_r != in_data) begin
                            err_r <= 1'b1;
                        end else begin
                            err_r <= err_r;
                        end
`endif
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                    S_RUNNING: begin
                        if (in_data == CMD_HALT) begin
                            state_r    <= S_IDLE;
                            core_rst_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r    <= S_IDLE;
                        busy_r     <= 1'b0;
                        core_rst_r <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: directed frames, expected writes queued, monitor compares pulses.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        core_rst;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic        dm;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          gap = 0;

    boot_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .core_rst(core_rst), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        check("in_ready before byte", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends a complete load frame for the words in wq and queues the expected writes.
    task automatic load_frame(input logic [7:0] cmd, input logic [7:0] addr);
        int         n;
        logic [7:0] cs;
        logic [7:0] a;
        logic [31:0] w;
        n  = wq.size();
        cs = 8'h00;
        send(cmd);
        send(addr);
        send(n[7:0]);
        check("busy in frame", {63'd0, busy}, 64'd1);
        for (int i = 0; i < n; i++) begin
            w = wq[i];
            a = addr + 8'(i);
            exp_q.push_back({cmd == 8'h02, a, w});
            for (int k = 3; k >= 0; k--) begin
                cs = cs ^ w[k*8 +: 8];
                send(w[k*8 +: 8]);
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send(cs);
`endif
        @(negedge clk);
    endtask

    // Monitor: every write pulse is popped against the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we || dmem_we) begin
                check("single write strobe", {63'd0, imem_we & dmem_we}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected write", {23'd0, dmem_we, dmem_we ? dmem_addr : imem_addr,
                          dmem_we ? dmem_wdata : imem_wdata}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {23'd0, dmem_we, dmem_we ? dmem_addr : imem_addr,
                          dmem_we ? dmem_wdata : imem_wdata}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", {63'd0, in_ready}, 64'd0);
        check("reset core_rst", {63'd0, core_rst}, 64'd1);
        check("reset we", {62'd0, imem_we, dmem_we}, 64'd0);
        check("reset addrs", {48'd0, imem_addr, dmem_addr}, 64'd0);
        check("reset imem_wdata", {32'd0, imem_wdata}, 64'd0);
        check("reset dmem_wdata", {32'd0, dmem_wdata}, 64'd0);
        check("reset busy/err", {62'd0, busy, err}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready after reset", {63'd0, in_ready}, 64'd1);

        // IMEM load of two instructions
        wq = '{32'h2008000A, 32'h8C090000};
        load_frame(8'h01, 8'h00);
        check("busy after imem frame", {63'd0, busy}, 64'd0);
        check("err after imem frame", {63'd0, err}, 64'd0);
        check("imem_addr hold", {56'd0, imem_addr}, 64'h01);
        check("imem_wdata hold", {32'd0, imem_wdata}, 64'h8C090000);

        // DMEM load wrapping past 0xFF, with idle gaps between bytes
        gap = 2;
        wq = '{32'h11223344, 32'hAABBCCDD};
        load_frame(8'h02, 8'hFF);
        gap = 0;
        check("dmem_addr hold after wrap", {56'd0, dmem_addr}, 64'h00);
        check("busy after dmem frame", {63'd0, busy}, 64'd0);

        // Error blocks RUN until CLR_ERR
        send(8'h7E);
        check("err on bad cmd", {63'd0, err}, 64'd1);
        send(8'h03);
        check("run refused core_rst", {63'd0, core_rst}, 64'd1);
        send(8'h05);
        check("err cleared", {63'd0, err}, 64'd0);
        send(8'h03);
        check("run core_rst", {63'd0, core_rst}, 64'd0);
        check("busy running", {63'd0, busy}, 64'd0);

        // RUNNING: stray byte flags error, HALT returns to IDLE
        send(8'h01);
        check("err on stray byte running", {63'd0, err}, 64'd1);
        check("still running", {63'd0, core_rst}, 64'd0);
        send(8'h04);
        check("halt core_rst", {63'd0, core_rst}, 64'd1);
        send(8'h05);
        check("err cleared after halt", {63'd0, err}, 64'd0);
        wq = '{32'hDEADBEEF};
        load_frame(8'h01, 8'h10);
        check("busy after post-halt frame", {63'd0, busy}, 64'd0);

        // Reset mid-word discards the partial word
        send(8'h01);
        send(8'h20);
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("busy after mid reset", {63'd0, busy}, 64'd0);
        check("core_rst after mid reset", {63'd0, core_rst}, 64'd1);
        @(posedge clk);
        #1;
        wq = '{32'h12345678};
        load_frame(8'h01, 8'h30);
        check("imem_addr after reset frame", {56'd0, imem_addr}, 64'h30);

        // COUNT=0 means 256 words; addresses wrap around the full depth
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(32'h01010101 * i ^ 32'hA5000000);
        load_frame(8'h01, 8'h80);
        check("imem_addr after 256 words", {56'd0, imem_addr}, 64'h7F);
        check("busy after 256 words", {63'd0, busy}, 64'd0);

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum: words still written, err set, RUN refused
        begin
            logic [7:0] cs;
            cs = 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07 ^ 8'h08;
            send(8'h01);
            send(8'h40);
            send(8'h02);
            exp_q.push_back({1'b0, 8'h40, 32'h01020304});
            exp_q.push_back({1'b0, 8'h41, 32'h05060708});
            for (int i = 1; i <= 8; i++) send(8'(i));
            send(cs ^ 8'hFF);
            check("err on bad csum", {63'd0, err}, 64'd1);
            send(8'h03);
            check("run refused after bad csum", {63'd0, core_rst}, 64'd1);
            send(8'h05);
            check("err cleared after csum", {63'd0, err}, 64'd0);
        end
`endif

        repeat (3) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
